// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared defaults and default memory image for the sequence datapath
package seq_pkg;

  localparam int SEQ_DATA_W = 4;
  localparam int SEQ_ADDR_W = 4;
  localparam int SEQ_DEPTH  = 16;

  // Default game sequence: 1,4,7,10,13,0,3,... wrapped to the word width.
  function automatic int default_word(input int idx, input int data_w);
    return (3 * idx + 1) % (1 << data_w);
  endfunction

endpackage

// File: rtl/seq_fluxo_dados_param_if.sv
// rtl/seq_fluxo_dados_param_if.sv - control/status bundle between game control unit and datapath
// Optional escreveM signal present when SEQ_RAM_WRITE_EN is defined.
interface seq_fluxo_dados_param_if
  import seq_pkg::*;
#(
  parameter int DATA_W = SEQ_DATA_W,
  parameter int ADDR_W = SEQ_ADDR_W
);

  logic [DATA_W-1:0] chaves;
  logic              zeraR;
  logic              registraR;
  logic              zeraC;
  logic              contaC;
  logic [ADDR_W-1:0] limite;
  logic              verificaR;
`ifdef SEQ_RAM_WRITE_EN
  logic              escreveM;
`endif
  logic              chavesIgualMemoria;
  logic              chavesMaiorMemoria;
  logic              chavesMenorMemoria;
  logic              fimC;
  logic [ADDR_W:0]   acertos;
  logic              erro;
  logic [ADDR_W-1:0] db_contagem;
  logic [DATA_W-1:0] db_chaves;
  logic [DATA_W-1:0] db_memoria;

  modport master (
`ifdef SEQ_RAM_WRITE_EN
    output escreveM,
`endif
    output chaves, zeraR, registraR, zeraC, contaC, limite, verificaR,
    input  chavesIgualMemoria, chavesMaiorMemoria, chavesMenorMemoria,
    input  fimC, acertos, erro, db_contagem, db_chaves, db_memoria
  );

  modport slave (
`ifdef SEQ_RAM_WRITE_EN
    input  escreveM,
`endif
    input  chaves, zeraR, registraR, zeraC, contaC, limite, verificaR,
    output chavesIgualMemoria, chavesMaiorMemoria, chavesMenorMemoria,
    output fimC, acertos, erro, db_contagem, db_chaves, db_memoria
  );

endinterface

// File: rtl/seq_mem_sync.sv
// rtl/seq_mem_sync.sv - synchronous sequence memory with registered output
// ROM of the default image; SEQ_RAM_WRITE_EN adds a read-before-write port.
module seq_mem_sync
  import seq_pkg::*;
#(
  parameter int DATA_W = SEQ_DATA_W,
  parameter int ADDR_W = SEQ_ADDR_W,
  parameter int DEPTH  = SEQ_DEPTH
)
(
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
`ifdef SEQ_RAM_WRITE_EN
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
`endif
  output logic [DATA_W-1:0] rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IDX_W-1:0] idx;
  logic             unused_addr;

  // Upper address bits are always zero because the limit is clamped below DEPTH.
  assign idx         = addr[IDX_W-1:0];
  assign unused_addr = ^addr;

`ifdef SEQ_RAM_WRITE_EN
  typedef logic [DATA_W-1:0] image_t [DEPTH];

  function automatic image_t default_image();
    image_t img;
    for (int i = 0; i < DEPTH; i++) img[i] = DATA_W'(default_word(i, DATA_W));
    return img;
  endfunction

  image_t mem = default_image();

  // Contents survive reset; only the output register is cleared.
  always_ff @(posedge clock) begin
    if (reset) rdata <= '0;
    else       rdata <= mem[idx];
    if (we && !reset) mem[idx] <= wdata;
  end
`else
  always_ff @(posedge clock) begin
    if (reset) rdata <= '0;
    else       rdata <= DATA_W'(default_word(int'(idx), DATA_W));
  end
`endif

endmodule

// File: rtl/seq_fluxo_dados_param.sv
// rtl/seq_fluxo_dados_param.sv - memory-game sequence datapath: counter, switch register, compare, score
// Build option SEQ_RAM_WRITE_EN makes the sequence memory writable from the switch register.
module seq_fluxo_dados_param
  import seq_pkg::*;
#(
  parameter int DATA_W = SEQ_DATA_W,
  parameter int ADDR_W = SEQ_ADDR_W,
  parameter int DEPTH  = SEQ_DEPTH
)
(
  input logic                   clock,
  input logic                   reset,
  seq_fluxo_dados_param_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   ACERTOS_MAX = '1;

  logic [ADDR_W-1:0] contagem;
  logic [ADDR_W-1:0] limite_q;
  logic [ADDR_W-1:0] limite_clamped;
  logic [DATA_W-1:0] chaves_q;
  logic [DATA_W-1:0] memoria_q;
  logic [ADDR_W:0]   acertos_q;
  logic              erro_q;
  logic              igual;

  // Keeps the memory address inside 0..DEPTH-1 whatever the control unit programs.
  always_comb begin
    limite_clamped = bus.limite;
    if (int'(bus.limite) > DEPTH - 1) limite_clamped = LAST_ADDR;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      contagem <= '0;
      limite_q <= LAST_ADDR;
    end else if (bus.zeraC) begin
      contagem <= '0;
      limite_q <= limite_clamped;
    end else if (bus.contaC) begin
      contagem <= (contagem == limite_q) ? '0 : contagem + ADDR_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || bus.zeraR) chaves_q <= '0;
    else if (bus.registraR) chaves_q <= bus.chaves;
  end

  seq_mem_sync #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clock  (clock),
    .reset  (reset),
    .addr   (contagem),
`ifdef SEQ_RAM_WRITE_EN
    .we     (bus.escreveM),
    .wdata  (chaves_q),
`endif
    .rdata  (memoria_q)
  );

  assign igual = (chaves_q == memoria_q);

  // Score uses the comparator as seen in the strobe cycle; a restart always wins.
  always_ff @(posedge clock) begin
    if (reset || bus.zeraC) begin
      acertos_q <= '0;
      erro_q    <= 1'b0;
    end else if (bus.verificaR) begin
      if (!igual)                          erro_q    <= 1'b1;
      else if (acertos_q != ACERTOS_MAX)   acertos_q <= acertos_q + (ADDR_W+1)'(1);
    end
  end

  assign bus.chavesIgualMemoria = igual;
  assign bus.chavesMaiorMemoria = (chaves_q > memoria_q);
  assign bus.chavesMenorMemoria = (chaves_q < memoria_q);
  assign bus.fimC               = (contagem == limite_q);
  assign bus.acertos            = acertos_q;
  assign bus.erro               = erro_q;
  assign bus.db_contagem        = contagem;
  assign bus.db_chaves          = chaves_q;
  assign bus.db_memoria         = memoria_q;

endmodule

// File: tb/tb_seq_fluxo_dados_param.sv
// tb/tb_seq_fluxo_dados_param.sv - directed self-checking bench for seq_fluxo_dados_param
// Exercises the SEQ_RAM_WRITE_EN write path when that macro is defined.
module tb_seq_fluxo_dados_param;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;

  seq_fluxo_dados_param_if #(.DATA_W(4), .ADDR_W(5)) b ();
  seq_fluxo_dados_param_if #(.DATA_W(4), .ADDR_W(2)) s ();

  seq_fluxo_dados_param #(.DATA_W(4), .ADDR_W(5), .DEPTH(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (b)
  );

  seq_fluxo_dados_param #(.DATA_W(4), .ADDR_W(2), .DEPTH(4)) dut_s (
    .clock (clock),
    .reset (reset),
    .bus   (s)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_cnt [4];
    logic [31:0] exp_mem [4];
    logic [31:0] exp_fim [4];
    exp_cnt = '{1, 2, 3, 0};
    exp_mem = '{1, 4, 7, 10};
    exp_fim = '{0, 0, 1, 0};

    b.chaves = '0; b.zeraR = 0; b.registraR = 0; b.zeraC = 0;
    b.contaC = 0; b.limite = '0; b.verificaR = 0;
    s.chaves = '0; s.zeraR = 0; s.registraR = 0; s.zeraC = 0;
    s.contaC = 0; s.limite = '0; s.verificaR = 0;
`ifdef SEQ_RAM_WRITE_EN
    b.escreveM = 0;
    s.escreveM = 0;
`endif

    step(); step();
    check("rst_cnt",  32'(b.db_contagem), 0);
    check("rst_sw",   32'(b.db_chaves),   0);
    check("rst_acc",  32'(b.acertos),     0);
    check("rst_err",  32'(b.erro),        0);
    check("rst_fim",  32'(b.fimC),        0);
    check("rst_mem",  32'(b.db_memoria),  0);
    reset = 0;
    step();
    check("mem0_after_rst", 32'(b.db_memoria), 1);

    b.limite = 5'd3; b.zeraC = 1;
    step();
    b.zeraC = 0; b.contaC = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("seq_cnt%0d", i), 32'(b.db_contagem), exp_cnt[i]);
      check($sformatf("seq_fim%0d", i), 32'(b.fimC),        exp_fim[i]);
      check($sformatf("seq_mem%0d", i), 32'(b.db_memoria),  exp_mem[i]);
    end
    b.contaC = 0;
    step();
    check("seq_mem_wrap", 32'(b.db_memoria), 1);

    b.contaC = 1;
    step();
    b.contaC = 0; b.chaves = 4'h4; b.registraR = 1;
    step();
    b.registraR = 0;
    check("eq_sw",    32'(b.db_chaves),          4);
    check("eq_igual", 32'(b.chavesIgualMemoria), 1);
    b.verificaR = 1;
    step();
    b.verificaR = 0;
    check("eq_acc", 32'(b.acertos), 1);
    check("eq_err", 32'(b.erro),    0);

    b.chaves = 4'h2; b.registraR = 1;
    step();
    b.registraR = 0;
    check("lt_menor", 32'(b.chavesMenorMemoria), 1);
    check("lt_igual", 32'(b.chavesIgualMemoria), 0);
    check("lt_maior", 32'(b.chavesMaiorMemoria), 0);
    b.verificaR = 1;
    step();
    b.verificaR = 0;
    check("lt_err", 32'(b.erro),    1);
    check("lt_acc", 32'(b.acertos), 1);

    b.chaves = 4'h9; b.registraR = 1;
    step();
    b.registraR = 0;
    check("gt_maior", 32'(b.chavesMaiorMemoria), 1);
    check("gt_menor", 32'(b.chavesMenorMemoria), 0);

    b.chaves = 4'h5; b.zeraR = 1; b.registraR = 1;
    step();
    b.zeraR = 0; b.registraR = 0;
    check("zeraR_wins", 32'(b.db_chaves), 0);

    b.limite = 5'd20; b.zeraC = 1; b.contaC = 1; b.verificaR = 1;
    step();
    b.zeraC = 0; b.contaC = 0; b.verificaR = 0;
    check("clr_cnt", 32'(b.db_contagem), 0);
    check("clr_acc", 32'(b.acertos),     0);
    check("clr_err", 32'(b.erro),        0);
    b.contaC = 1;
    for (int i = 0; i < 15; i++) step();
    check("clamp_cnt", 32'(b.db_contagem), 15);
    check("clamp_fim", 32'(b.fimC),        1);
    step();
    check("clamp_wrap", 32'(b.db_contagem), 0);
    check("mem15",      32'(b.db_memoria),  14);
    step(); step();
    b.contaC = 0;
    check("mid_cnt", 32'(b.db_contagem), 2);

    reset = 1;
    step();
    check("midrst_cnt", 32'(b.db_contagem), 0);
    check("midrst_mem", 32'(b.db_memoria),  0);
    check("midrst_fim", 32'(b.fimC),        0);
    reset = 0;
    step();
    check("midrst_mem0", 32'(b.db_memoria), 1);

    s.chaves = 4'h1; s.registraR = 1;
    step();
    s.registraR = 0;
    check("sat_igual", 32'(s.chavesIgualMemoria), 1);
    s.verificaR = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 2) check("sat_acc3", 32'(s.acertos), 3);
    end
    s.verificaR = 0;
    check("sat_acc", 32'(s.acertos), 7);
    check("sat_err", 32'(s.erro),    0);

`ifdef SEQ_RAM_WRITE_EN
    b.limite = 5'd15; b.zeraC = 1;
    step();
    b.zeraC = 0; b.chaves = 4'hF; b.registraR = 1; b.contaC = 1;
    step();
    b.registraR = 0;
    step();
    b.contaC = 0;
    check("wr_addr", 32'(b.db_contagem), 2);
    b.escreveM = 1;
    step();
    b.escreveM = 0;
    check("wr_old", 32'(b.db_memoria), 7);
    step();
    check("wr_new", 32'(b.db_memoria), 15);
    reset = 1;
    step();
    reset = 0;
    step();
    check("wr_mem0", 32'(b.db_memoria), 1);
    b.contaC = 1;
    step(); step();
    b.contaC = 0;
    step();
    check("wr_kept", 32'(b.db_memoria), 15);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
